move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 166 ++++++++++++++++
 tb/tb_move_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Move sequencer for a 4x4 tile board: walks the four lines of the board
// in the requested direction through an external single-line merge unit.
module move_sequencer #(
  parameter int TILE_W  = 12,
  parameter int SCORE_W = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [3:0]                       direction,
  input  logic [3:0][3:0][TILE_W-1:0]      board_in,
  output logic [3:0][TILE_W-1:0]           line_to_unit,
  input  logic [3:0][TILE_W-1:0]           line_from_unit,
  input  logic [12:0]                      line_score,
  output logic                             busy,
  output logic                             done,
  output logic [3:0][3:0][TILE_W-1:0]      board_out,
  output logic [SCORE_W-1:0]               score_add,
  output logic                             moved
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [1:0]                    k_q, k_d;
  logic [3:0]                    dir_q, dir_d;
  logic [3:0][3:0][TILE_W-1:0]   board_q, board_d;
  logic [SCORE_W-1:0]            score_q, score_d;
  logic                          moved_q, moved_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  // Element 0 of every line is the merge destination, so the far edge maps to e=0.
  function automatic logic [1:0] cell_row(input logic [3:0] dir, input logic [1:0] k,
                                          input logic [1:0] e);
    case (dir)
      4'b0001: cell_row = e;
      4'b0010: cell_row = 2'd3 - e;
      default: cell_row = k;
    endcase
  endfunction

  function automatic logic [1:0] cell_col(input logic [3:0] dir, input logic [1:0] k,
                                          input logic [1:0] e);
    case (dir)
      4'b0100: cell_col = e;
      4'b1000: cell_col = 2'd3 - e;
      default: cell_col = k;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [3:0] d);
    is_onehot = (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

  // Saturating accumulate; one extra bit catches the carry out.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc,
                                                 input logic [12:0] inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, acc} + (SCORE_W+1)'(inc);
    if (sum[SCORE_W]) begin
      sat_add = {SCORE_W{1'b1}};
    end else begin
      sat_add = sum[SCORE_W-1:0];
    end
  endfunction

  // Present the current line of the working board to the merge unit.
  always_comb begin
    line_to_unit = '0;
    if (state_q == LINE) begin
      for (int e = 0; e < 4; e++) begin
        line_to_unit[e] = board_q[cell_row(dir_q, k_q, 2'(e))][cell_col(dir_q, k_q, 2'(e))];
      end
    end else begin
      line_to_unit = '0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dir_d   = dir_q;
    board_d = board_q;
    score_d = score_q;
    moved_d = moved_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          board_d = board_in;
          score_d = '0;
          moved_d = 1'b0;
          k_d     = 2'd0;
          if (is_onehot(direction)) begin
            dir_d   = direction;
            state_d = LINE;
          end else begin
            state_d = FINISH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LINE: begin
        for (int e = 0; e < 4; e++) begin
          board_d[cell_row(dir_q, k_q, 2'(e))][cell_col(dir_q, k_q, 2'(e))] = line_from_unit[e];
        end
        score_d = sat_add(score_q, line_score);
        if (line_from_unit != line_to_unit) begin
          moved_d = 1'b1;
        end else begin
          moved_d = moved_q;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = FINISH;
        end else begin
          state_d = LINE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      dir_q   <= 4'd0;
      board_q <= '0;
      score_q <= '0;
      moved_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dir_q   <= dir_d;
      board_q <= board_d;
      score_q <= score_d;
      moved_q <= moved_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign board_out = board_q;
  assign score_add = score_q;
  assign moved     = moved_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: a behavioural merge unit, a
// move-level reference model, directed literal cases and random traffic.
module tb_move_sequencer;

  localparam int TW = 12;
  localparam int SW = 14;
  localparam int SAT = 16383;

  typedef logic [3:0][TW-1:0]      line_t;
  typedef logic [3:0][3:0][TW-1:0] board_t;
  typedef struct packed {
    logic [12:0] sc;
    line_t       ln;
  } merge_t;

  logic          clk = 1'b0;
  logic          rst, start, sat_mode;
  logic [3:0]    direction;
  board_t        board_in, board_out;
  line_t         line_to_unit, line_from_unit;
  logic [12:0]   line_score;
  logic          busy, done, moved;
  logic [SW-1:0] score_add;
  merge_t        mres;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  move_sequencer #(.TILE_W(TW), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .direction(direction),
    .board_in(board_in), .line_to_unit(line_to_unit),
    .line_from_unit(line_from_unit), .line_score(line_score),
    .busy(busy), .done(done), .board_out(board_out),
    .score_add(score_add), .moved(moved)
  );

  always #5 clk = ~clk;

  // 2048-style line merge: compact nonzero tiles, merge equal neighbours once.
  function automatic merge_t merge(input line_t in);
    merge_t r;
    int v[4];
    int n, i, m;
    r = '0;
    n = 0;
    for (int j = 0; j < 4; j++) v[j] = 0;
    for (int j = 0; j < 4; j++) begin
      if (in[j] != '0) begin
        v[n] = int'(in[j]);
        n++;
      end
    end
    i = 0;
    m = 0;
    while (i < n) begin
      if (i + 1 < n && v[i] == v[i+1]) begin
        r.ln[m] = TW'(2 * v[i]);
        r.sc    = r.sc + 13'(2 * v[i]);
        i += 2;
      end else begin
        r.ln[m] = TW'(v[i]);
        i += 1;
      end
      m++;
    end
    return r;
  endfunction

  always_comb begin
    mres           = merge(line_to_unit);
    line_from_unit = mres.ln;
    line_score     = sat_mode ? 13'd8191 : mres.sc;
  end

  function automatic line_t get_line(input board_t b, input logic [3:0] d, input int k);
    line_t ln;
    for (int e = 0; e < 4; e++) begin
      case (d)
        4'b0100: ln[e] = b[k][e];
        4'b1000: ln[e] = b[k][3-e];
        4'b0001: ln[e] = b[e][k];
        default: ln[e] = b[3-e][k];
      endcase
    end
    return ln;
  endfunction

  function automatic board_t model_board(input board_t b, input logic [3:0] d);
    board_t r;
    merge_t mr;
    r = b;
    for (int k = 0; k < 4; k++) begin
      mr = merge(get_line(b, d, k));
      for (int e = 0; e < 4; e++) begin
        case (d)
          4'b0100: r[k][e]   = mr.ln[e];
          4'b1000: r[k][3-e] = mr.ln[e];
          4'b0001: r[e][k]   = mr.ln[e];
          default: r[3-e][k] = mr.ln[e];
        endcase
      end
    end
    return r;
  endfunction

  function automatic int model_score(input board_t b, input logic [3:0] d, input bit sat);
    int s;
    merge_t mr;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      mr = merge(get_line(b, d, k));
      s += sat ? 8191 : int'(mr.sc);
    end
    return (s > SAT) ? SAT : s;
  endfunction

  function automatic board_t rand_board();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = ($urandom_range(0, 2) == 0) ? '0 :
                  TW'(1 << (($urandom_range(0, 7) == 0) ? $urandom_range(1, 10) : $urandom_range(1, 3)));
    return b;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the move timeline and the outputs it must produce.
  bit         m_busy, m_inline, m_done, o_moved;
  int         m_k, o_score, p_score;
  logic [3:0] m_dir;
  board_t     m_orig, p_board, o_board;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_inline <= 1'b0; m_done <= 1'b0; m_k <= 0;
      o_board <= '0; o_score <= 0; o_moved <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        if ($onehot(direction)) begin
          m_inline <= 1'b1; m_k <= 0; m_orig <= board_in; m_dir <= direction;
          p_board <= model_board(board_in, direction);
          p_score <= model_score(board_in, direction, sat_mode);
        end else begin
          m_done <= 1'b1; o_board <= board_in; o_score <= 0; o_moved <= 1'b0;
        end
      end
    end else if (m_inline) begin
      if (m_k == 3) begin
        m_inline <= 1'b0; m_done <= 1'b1;
        o_board <= p_board; o_score <= p_score; o_moved <= (p_board != m_orig);
      end else begin
        m_k <= m_k + 1;
      end
    end else begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("line_to_unit", line_to_unit, m_inline ? get_line(m_orig, m_dir, m_k) : line_t'('0));
      if (!m_inline) begin
        chk("board_out", board_out, o_board);
        chk("score_add", score_add, o_score);
        chk("moved", moved, o_moved);
      end
    end
  end

  task automatic wait_done(input string nm, input int elat, output bit seen);
    int lat;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat = i;
      end
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
    chk({nm, "_latency"}, lat, elat);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic run_move(input string nm, input board_t b, input logic [3:0] d,
                          input board_t eb, input int es, input bit em, input int elat);
    bit seen;
    board_in = b; direction = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(nm, elat, seen);
    chk({nm, "_board"}, board_out, eb);
    chk({nm, "_score"}, score_add, es);
    chk({nm, "_moved"}, moved, em);
    chk({nm, "_model_board"}, o_board, eb);
    chk({nm, "_model_score"}, o_score, es);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    board_t b, eb;
    bit seen;
    rst = 1'b1; start = 1'b0; direction = 4'd0; board_in = '0; sat_mode = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    start = 1'b1; direction = 4'b0100; board_in = rand_board();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_board", board_out, '0);
    chk("rst_score", score_add, '0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    b = '0; b[0][0] = 12'd2; b[0][1] = 12'd2; b[0][2] = 12'd4;
    eb = '0; eb[0][0] = 12'd4; eb[0][1] = 12'd4;
    run_move("left", b, 4'b0100, eb, 4, 1'b1, 5);

    b = '0; b[0][1] = 12'd2; b[0][2] = 12'd2; b[0][3] = 12'd2;
    eb = '0; eb[0][2] = 12'd2; eb[0][3] = 12'd4;
    run_move("right", b, 4'b1000, eb, 4, 1'b1, 5);

    b = '0; b[0][0] = 12'd2; b[1][0] = 12'd4; b[2][0] = 12'd8; b[3][0] = 12'd16;
    run_move("top", b, 4'b0001, b, 0, 1'b0, 5);

    b = '0; b[0][0] = 12'd2; b[1][0] = 12'd2;
    eb = '0; eb[3][0] = 12'd4;
    run_move("bottom", b, 4'b0010, eb, 4, 1'b1, 5);

    b = rand_board(); b[0][0] = 12'd8; b[0][1] = 12'd8;
    run_move("invalid", b, 4'b0011, b, 0, 1'b0, 1);

    // Second start mid-move with new direction/board, then start in FINISH.
    b = '0; b[0][0] = 12'd2; b[0][1] = 12'd2; b[0][2] = 12'd4;
    eb = '0; eb[0][0] = 12'd4; eb[0][1] = 12'd4;
    board_in = b; direction = 4'b0100; start = 1'b1;
    @(posedge clk); #1;
    direction = 4'b1000; board_in = rand_board();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_ign", 4, seen);
    chk("busy_ign_board", board_out, eb);
    chk("busy_ign_score", score_add, 4);
    start = 1'b1; direction = 4'b0100;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("finish_start_ign", busy, 1'b0);
    @(posedge clk); #1;

    // Reset while processing line 2.
    board_in = b; direction = 4'b0100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_k2_busy", busy, 1'b0);
    chk("rst_k2_board", board_out, '0);
    repeat (6) begin @(negedge clk); chk("rst_k2_nodone", done, 1'b0); end
    @(posedge clk); #1;

    // Reset on the edge that would process the last line.
    board_in = b; direction = 4'b0100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(negedge clk); chk("rst_last_nodone", done, 1'b0); end
    @(posedge clk); #1;

    sat_mode = 1'b1;
    board_in = rand_board(); direction = 4'b0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("sat", 5, seen);
    chk("sat_score", score_add, SAT);
    chk("sat_model_score", o_score, SAT);
    @(posedge clk); #1;
    sat_mode = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      start     = ($urandom_range(0, 3) == 0);
      direction = ($urandom_range(0, 5) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      board_in  = rand_board();
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
